// File: rtl/tohost_mon_pkg.sv
// tohost_monitor shared types and helpers.
// State encoding, pass constant and failing-code predicate.
package tohost_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TMO
   } trk_state_t;

   localparam int unsigned TOHOST_PASS = 1;
   localparam logic [31:0] DEF_TOHOST_ADDR = 32'h8000_1000;
   localparam int MAX_DW = 128;

   // Odd values other than 1 carry a failing test number in the upper bits.
   function automatic logic is_fail(input logic [MAX_DW-1:0] data);
      return data[0] && (data != MAX_DW'(TOHOST_PASS));
   endfunction

endpackage

// File: rtl/tohost_core_tracker.sv
// Per-core tohost tracker: FSM, watchdog counter and fail code.
// The hit input is already qualified by core id and address.
module tohost_core_tracker
   import tohost_mon_pkg::*;
#(
   parameter int          DATA_WIDTH     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int          CNT_WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  start,
   input  logic                  hit,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  pass,
   output logic                  fail,
   output logic                  tmo,
   output logic [DATA_WIDTH-2:0] code,
   output logic                  term_next,
   output logic                  fail_next
);

   localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_WIDTH-1:0] EXPIRE =
      CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   trk_state_t state, state_n;
   logic [CNT_WIDTH-1:0] cnt, cnt_n;
   logic [DATA_WIDTH-2:0] code_n;
   logic hit_pass, hit_fail;

   assign hit_pass = hit && (data == DATA_WIDTH'(TOHOST_PASS));
   assign hit_fail = hit && is_fail(MAX_DW'(data));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         code  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         code  <= code_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      code_n  = code;
      unique case (state)
         ST_IDLE: begin
            if (en && start) begin
               state_n = ST_RUN;
               cnt_n   = '0;
               code_n  = '0;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               if (start) cnt_n = '0;
               else if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
               // A terminating hit wins over expiry in the same cycle.
               if (hit_pass) begin
                  state_n = ST_PASS;
               end else if (hit_fail) begin
                  state_n = ST_FAIL;
                  code_n  = data[DATA_WIDTH-1:1];
               end else if (WDOG_EN && !start && cnt == EXPIRE) begin
                  state_n = ST_TMO;
               end
            end
         end
         ST_PASS, ST_FAIL, ST_TMO: begin
            if (en && start) begin
               state_n = ST_RUN;
               cnt_n   = '0;
               code_n  = '0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign pass = (state == ST_PASS);
   assign fail = (state == ST_FAIL) || (state == ST_TMO);
   assign tmo  = (state == ST_TMO);

   assign term_next = (state_n == ST_PASS) || (state_n == ST_FAIL) ||
                      (state_n == ST_TMO);
   assign fail_next = (state_n == ST_FAIL) || (state_n == ST_TMO);

endmodule

// File: rtl/tohost_monitor.sv
// Snoops core write traffic for the tohost mailbox.
// One tracker per core plus aggregate done/fail flags.
module tohost_monitor
   import tohost_mon_pkg::*;
#(
   parameter int              NUM_CORES      = 4,
   parameter int              ADDR_WIDTH     = 32,
   parameter int              DATA_WIDTH     = 64,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR =
      ADDR_WIDTH'(DEF_TOHOST_ADDR),
   parameter int unsigned     TIMEOUT_CYCLES = 1_000_000,
   parameter int              CNT_WIDTH      = 32,
   localparam int             CORE_W =
      (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CORES-1:0]              check_en,
   input  logic [NUM_CORES-1:0]              start,
   input  logic                              wr_valid,
   input  logic [CORE_W-1:0]                 wr_core,
   input  logic [ADDR_WIDTH-1:0]             wr_addr,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   output logic [NUM_CORES-1:0]              pass_status,
   output logic [NUM_CORES-1:0]              fail_status,
   output logic [NUM_CORES-1:0]              timeout,
   output logic [NUM_CORES*(DATA_WIDTH-1)-1:0] fail_code,
   output logic                              all_done,
   output logic                              any_fail
);

   logic [NUM_CORES-1:0] hit;
   logic [NUM_CORES-1:0] term_n;
   logic [NUM_CORES-1:0] fail_n;
   logic addr_hit;

   assign addr_hit = wr_valid && (wr_addr == TOHOST_ADDR);

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
      // Ids beyond NUM_CORES never match any instance.
      assign hit[g] = addr_hit && (wr_core == CORE_W'(g));

      tohost_core_tracker #(
         .DATA_WIDTH     (DATA_WIDTH),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .CNT_WIDTH      (CNT_WIDTH)
      ) u_trk (
         .clk       (clk),
         .reset     (reset),
         .en        (check_en[g]),
         .start     (start[g]),
         .hit       (hit[g]),
         .data      (wr_data),
         .pass      (pass_status[g]),
         .fail      (fail_status[g]),
         .tmo       (timeout[g]),
         .code      (fail_code[g*(DATA_WIDTH-1) +: (DATA_WIDTH-1)]),
         .term_next (term_n[g]),
         .fail_next (fail_n[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         all_done <= 1'b0;
         any_fail <= 1'b0;
      end else begin
         all_done <= (|check_en) && (&(term_n | ~check_en));
         any_fail <= |fail_n;
      end
   end

endmodule
